// File: rtl/cond_exec_unit.sv
// Condition-code evaluator: NZCV status register, NUM_LANES condition lanes and
// an IT-block sequencer that steers lane 0 while a block is in flight.

module cond_eval_lane (
  input  logic [3:0] code,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v, base;

  always_comb begin
    {n, z, c, v} = flags;
    base = 1'b1;
    case (code[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    // Odd codes are the complement of their even partner; 111x is always true.
    pass = (code[3:1] == 3'b111) ? 1'b1 : (base ^ code[0]);
  end
endmodule

module cond_exec_unit #(
  parameter int NUM_LANES = 2,
  parameter bit BYPASS    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*NUM_LANES-1:0] cond,
  input  logic [3:0]             flags_in,
  input  logic [3:0]             flags_we,
  output logic [3:0]             status_out,
  output logic [NUM_LANES-1:0]   cond_out,
  input  logic                   it_start,
  input  logic [3:0]             it_firstcond,
  input  logic [3:0]             it_mask,
  input  logic                   it_advance,
  output logic                   it_active,
  output logic [3:0]             it_cond,
  output logic                   it_err
);
  typedef enum logic {IDLE, ACTIVE} it_state_e;

  it_state_e                   state;
  logic [7:0]                  itstate;
  logic [3:0]                  merged;
  logic [3:0]                  eval_flags;
  logic [NUM_LANES-1:0][3:0]   lane_code;

  assign merged = (flags_we & flags_in) | (~flags_we & status_out);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status_out <= 4'b0000;
    else      status_out <= merged;
  end

  // Held in reset the lanes must see zero flags even on the bypass path.
  always_comb begin
    eval_flags = 4'b0000;
    if (rst) eval_flags = BYPASS ? merged : status_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      itstate <= 8'h00;
      it_err  <= 1'b0;
    end else begin
      it_err <= it_start && (state == ACTIVE || it_mask == 4'b0000);
      case (state)
        IDLE: begin
          if (it_start && it_mask != 4'b0000) begin
            state   <= ACTIVE;
            itstate <= {it_firstcond, it_mask};
          end
        end
        ACTIVE: begin
          if (it_advance) begin
            if (itstate[2:0] == 3'b000) begin
              state   <= IDLE;
              itstate <= 8'h00;
            end else begin
              itstate[4:0] <= {itstate[3:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign it_active = (state == ACTIVE);
  assign it_cond   = it_active ? itstate[7:4] : 4'b1110;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    if (g == 0) begin : g_it
      assign lane_code[g] = it_active ? it_cond : cond[3:0];
    end else begin : g_plain
      assign lane_code[g] = cond[4*g +: 4];
    end
    cond_eval_lane u_lane (
      .code  (lane_code[g]),
      .flags (eval_flags),
      .pass  (cond_out[g])
    );
  end
endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench: one registered-flag and one bypass instance share all inputs.

module tb_cond_exec_unit;
  logic       clk, rst;
  logic [7:0] cond;
  logic [3:0] flags_in, flags_we, it_firstcond, it_mask;
  logic       it_start, it_advance;

  logic [3:0] st0, st1, itc0, itc1;
  logic [1:0] co0, co1;
  logic       act0, act1, err0, err1;

  int n_cmp = 0;
  int n_err = 0;

  cond_exec_unit #(.NUM_LANES(2), .BYPASS(1'b0)) u_reg (
    .clk(clk), .rst(rst), .cond(cond), .flags_in(flags_in), .flags_we(flags_we),
    .status_out(st0), .cond_out(co0), .it_start(it_start), .it_firstcond(it_firstcond),
    .it_mask(it_mask), .it_advance(it_advance), .it_active(act0), .it_cond(itc0),
    .it_err(err0));

  cond_exec_unit #(.NUM_LANES(2), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .cond(cond), .flags_in(flags_in), .flags_we(flags_we),
    .status_out(st1), .cond_out(co1), .it_start(it_start), .it_firstcond(it_firstcond),
    .it_mask(it_mask), .it_advance(it_advance), .it_active(act1), .it_cond(itc1),
    .it_err(err1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_flags(input logic [3:0] v);
    flags_in = v;
    flags_we = 4'b1111;
    tick();
    flags_we = 4'b0000;
  endtask

  // {lane1 code, lane0 code, expected cond_out} with status = 1000
  logic [9:0] sgn_tab [5] = '{
    {4'b1010, 4'b1011, 2'b01},  // GE=0, LT=1
    {4'b1100, 4'b1101, 2'b01},  // GT=0, LE=1
    {4'b1000, 4'b1111, 2'b01},  // HI=0, 1111=1
    {4'b0100, 4'b0101, 2'b10},  // MI=1, PL=0
    {4'b0010, 4'b0011, 2'b01}   // CS=0, CC=1
  };

  initial begin
    rst = 1'b0; cond = {4'b0001, 4'b0000};
    flags_in = 4'b0000; flags_we = 4'b0000;
    it_start = 1'b0; it_firstcond = 4'b0000; it_mask = 4'b0000; it_advance = 1'b0;
    #2;
    chk("rst_status", {4'h0, st0}, 8'h00);
    chk("rst_active", {7'h0, act0}, 8'h00);
    chk("rst_itcond", {4'h0, itc0}, 8'h0e);
    chk("rst_err", {7'h0, err0}, 8'h00);
    chk("rst_co_reg", {6'h0, co0}, 8'h02);
    chk("rst_co_byp", {6'h0, co1}, 8'h02);
    tick();
    rst = 1'b1;

    // Z write: bypass sees it now, registered path one edge later
    flags_in = 4'b0100; flags_we = 4'b1111;
    #1;
    chk("byp_same_cyc", {6'h0, co1}, 8'h01);
    chk("reg_same_cyc", {6'h0, co0}, 8'h02);
    tick();
    flags_we = 4'b0000;
    #1;
    chk("reg_next_cyc", {6'h0, co0}, 8'h01);
    chk("status_z", {4'h0, st0}, 8'h04);

    // Masked write touches only C
    wr_flags(4'b1001);
    flags_in = 4'b0010; flags_we = 4'b0010;
    tick();
    flags_we = 4'b0000;
    chk("masked_reg", {4'h0, st0}, 8'h0b);
    chk("masked_byp", {4'h0, st1}, 8'h0b);

    wr_flags(4'b1000);
    for (int i = 0; i < 5; i++) begin
      cond = sgn_tab[i][9:2];
      #1;
      chk($sformatf("signed_reg%0d", i), {6'h0, co0}, {6'h0, sgn_tab[i][1:0]});
      chk($sformatf("signed_byp%0d", i), {6'h0, co1}, {6'h0, sgn_tab[i][1:0]});
    end

    // ITE EQ with Z set; lane0 raw code NE must be overridden
    wr_flags(4'b0100);
    cond = {4'b0000, 4'b0001};
    it_start = 1'b1; it_firstcond = 4'b0000; it_mask = 4'b1100;
    tick();
    it_start = 1'b0;
    chk("ite_active", {7'h0, act0}, 8'h01);
    chk("ite_cond0", {4'h0, itc0}, 8'h00);
    chk("ite_lane0_t", {6'h0, co0}, 8'h03);
    it_advance = 1'b1;
    tick();
    chk("ite_cond1", {4'h0, itc0}, 8'h01);
    chk("ite_lane0_e", {6'h0, co0}, 8'h02);
    tick();
    it_advance = 1'b0;
    chk("ite_done", {7'h0, act0}, 8'h00);
    chk("ite_idle_cond", {4'h0, itc0}, 8'h0e);
    chk("ite_idle_lane", {6'h0, co0}, 8'h02);
    chk("ite_no_err", {7'h0, err0}, 8'h00);

    // Start while active: error pulse, ITSTATE kept, advance still honoured
    it_start = 1'b1; it_firstcond = 4'b0001; it_mask = 4'b1000;
    tick();
    it_firstcond = 4'b0000; it_mask = 4'b0100;
    tick();
    it_start = 1'b0;
    chk("err_active", {7'h0, err0}, 8'h01);
    chk("err_keep_cond", {4'h0, itc0}, 8'h01);
    chk("err_keep_act", {7'h0, act0}, 8'h01);
    tick();
    chk("err_pulse_end", {7'h0, err0}, 8'h00);
    it_advance = 1'b1;
    tick();
    it_advance = 1'b0;
    chk("single_done", {7'h0, act0}, 8'h00);

    // Zero mask in IDLE
    it_start = 1'b1; it_mask = 4'b0000;
    tick();
    it_start = 1'b0;
    chk("err_zero_mask", {7'h0, err1}, 8'h01);
    chk("zero_mask_idle", {7'h0, act1}, 8'h00);
    tick();
    chk("err_zm_end", {7'h0, err1}, 8'h00);

    // Advance alone in IDLE does nothing; start+advance: start wins
    it_advance = 1'b1;
    tick();
    chk("adv_idle", {7'h0, act0}, 8'h00);
    it_start = 1'b1; it_firstcond = 4'b1010; it_mask = 4'b0100;
    tick();
    it_start = 1'b0; it_advance = 1'b0;
    chk("start_wins_act", {7'h0, act0}, 8'h01);
    chk("start_wins_cond", {4'h0, itc0}, 8'h0a);
    it_advance = 1'b1;
    tick();
    chk("two_slot_mid", {7'h0, act0}, 8'h01);
    chk("two_slot_cond", {4'h0, itc0}, 8'h0a);
    tick();
    it_advance = 1'b0;
    chk("two_slot_done", {7'h0, act0}, 8'h00);

    // Reset mid-IT, flags being written on the bypass path meanwhile
    wr_flags(4'b1111);
    cond = {4'b0001, 4'b0000};
    it_start = 1'b1; it_firstcond = 4'b0000; it_mask = 4'b1000;
    tick();
    it_start = 1'b0;
    chk("pre_rst_act", {7'h0, act0}, 8'h01);
    flags_in = 4'b1111; flags_we = 4'b1111;
    rst = 1'b0;
    #1;
    chk("mid_rst_act", {7'h0, act0}, 8'h00);
    chk("mid_rst_st", {4'h0, st0}, 8'h00);
    chk("mid_rst_co_reg", {6'h0, co0}, 8'h02);
    chk("mid_rst_co_byp", {6'h0, co1}, 8'h02);
    chk("mid_rst_itcond", {4'h0, itc1}, 8'h0e);
    flags_in = 4'b0100;
    #1;
    rst = 1'b1;
    tick();
    flags_we = 4'b0000;
    chk("post_rst_st", {4'h0, st0}, 8'h04);
    chk("post_rst_co", {6'h0, co0}, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cond_exec_unit.md
COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 2, giving the number of independent condition-evaluation lanes (legal 1..4).
REQ-002 The block SHALL have parameter BYPASS, default 0; 1 = evaluate against same-cycle merged flags, 0 = evaluate against registered flags.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port cond, input, 4*NUM_LANES bits: lane i condition code at [4i+3:4i].
REQ-006 The block SHALL have port flags_in, input, 4 bits: new NZCV value, with N at [3] and V at [0].
REQ-007 The block SHALL have port flags_we, input, 4 bits: per-flag write enable, aligned with flags_in.
REQ-008 The block SHALL have port status_out, output, 4 bits: registered NZCV.
REQ-009 The block SHALL have port cond_out, output, NUM_LANES bits: per-lane pass/fail.
REQ-010 The block SHALL have port it_start, input, 1 bit: begin an IT block.
REQ-011 The block SHALL have port it_firstcond, input, 4 bits: base condition of the IT block.
REQ-012 The block SHALL have port it_mask, input, 4 bits: IT mask; its lowest set bit marks the block length.
REQ-013 The block SHALL have port it_advance, input, 1 bit: one instruction of the IT block retired.
REQ-014 The block SHALL have ports it_active (output, 1 bit: IT block in progress) and it_cond (output, 4 bits: condition of the current IT slot).
REQ-015 The block SHALL have port it_err, output, 1 bit: registered one-cycle pulse on an illegal IT request.

Function
REQ-016 Flag register: each bit k SHALL load flags_in[k] on the clock edge when flags_we[k]=1 and hold otherwise.
REQ-017 Evaluation flags SHALL be the merged value (flags_we ? flags_in : status) when BYPASS=1, and status_out when BYPASS=0.
REQ-018 cond_out SHALL be combinational, with zero cycles latency from cond and the evaluation flags.
REQ-019 Codes 0000-0111 SHALL evaluate to: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
REQ-020 Codes 1000-1110 SHALL evaluate to: HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
REQ-021 Code 1111 SHALL evaluate true (unconditional).
REQ-022 The IT sequencer SHALL hold an 8-bit ITSTATE and use states IDLE and ACTIVE; it_active=1 exactly in ACTIVE.
REQ-023 IDLE->ACTIVE: on it_start=1 with it_mask!=0000, ITSTATE SHALL load {it_firstcond, it_mask}.
REQ-024 it_cond SHALL equal ITSTATE[7:4] in ACTIVE and 1110 in IDLE.
REQ-025 Advance in ACTIVE: if ITSTATE[2:0]==000, state SHALL go to IDLE with ITSTATE cleared; otherwise ITSTATE[4:0] SHALL shift left by 1 with zero fill and ITSTATE[7:5] held.
REQ-026 While ACTIVE, lane 0 SHALL evaluate it_cond in place of cond[3:0]; lanes 1..N-1 SHALL be unaffected.
REQ-027 Same-cycle it_start and it_advance in IDLE: start SHALL win and the advance is ignored.
REQ-028 it_advance in IDLE SHALL have no effect.
REQ-029 it_start in ACTIVE SHALL be ignored (ITSTATE unchanged, advance still honoured) and SHALL pulse it_err on the next cycle.
REQ-030 it_start with it_mask=0000 SHALL be ignored and SHALL pulse it_err on the next cycle.
REQ-031 Flag writes and IT sequencing SHALL be independent and may occur in the same cycle.

Reset
REQ-032 rst=0 at any time, including mid-IT-block, SHALL immediately force status_out=0000, IDLE, ITSTATE=00000000, it_err=0.
REQ-033 In reset, cond_out SHALL follow REQ-019..021 with flags 0000 (e.g. EQ=0, NE=1).
REQ-034 The first active clock edge after rst rises SHALL honour inputs normally.

Verification
REQ-035 Reset mid-IT: rst low during ACTIVE -> it_active=0, status_out=0000, cond 0000->0 and 0001->1 without waiting for a clock.
REQ-036 Flag write and bypass: flags_in=0100, flags_we=1111, cond=0000 -> BYPASS=1: cond_out[0]=1 same cycle; BYPASS=0: 0 same cycle, 1 next cycle.
REQ-037 Masked write: status=1001, flags_in=0010, flags_we=0010 -> status_out=1011; all other bits held.
REQ-038 Signed compares: status=1000 -> GE=0, LT=1, GT=0, LE=1, HI=0, code 1111=1.
REQ-039 ITE EQ: it_firstcond=0000, it_mask=1100, status=0100 -> it_cond=0000 and lane0=1; after first advance it_cond=0001 and lane0=0; after second advance it_active=0.
REQ-040 Errors: it_start while ACTIVE, and it_start with mask 0000 while IDLE -> one-cycle it_err pulse each; ITSTATE unchanged.
